// File: rtl/algo_4r6w1p_sched_pkg.sv
// rtl/algo_4r6w1p_sched_pkg.sv - shared types and default sizes for the 4r6w write scheduler
// Provides the bank/row/client-index types, the held-request record and the
// default geometry used as parameter defaults by the scheduler modules.
package algo_4r6w1p_sched_pkg;

  localparam int NUMREQ_DEF  = 8;
  localparam int NUMWRPT_DEF = 6;
  localparam int WIDTH_DEF   = 64;
  localparam int NUMVBNK_DEF = 8;
  localparam int BITVBNK_DEF = 3;
  localparam int BITVROW_DEF = 13;
  localparam int BITREQ_DEF  = 3;
  localparam int CNTW_DEF    = 16;

  typedef logic [BITVBNK_DEF-1:0] bank_t;
  typedef logic [BITVROW_DEF-1:0] row_t;
  typedef logic [BITREQ_DEF-1:0]  reqidx_t;

  typedef struct packed {
    bank_t                badr;
    row_t                 radr;
    logic [WIDTH_DEF-1:0] din;
  } wreq_t;

endpackage

// File: rtl/algo_4r6w1p_wr_grant.sv
// rtl/algo_4r6w1p_wr_grant.sv - combinational rotating bank-conflict-free write grant
// Ports:
//   pend      held-request valid per client
//   bank      held bank address per client
//   rr        client with top priority this cycle
//   ready     core ready; no grants when low
//   gnt       per-client grant
//   port_idx  client index driving each write port
//   port_vld  write port in use
//   conf_num  clients denied only because their bank was already claimed
module algo_4r6w1p_wr_grant
  import algo_4r6w1p_sched_pkg::*;
#(
  parameter int NUMREQ  = NUMREQ_DEF,
  parameter int NUMWRPT = NUMWRPT_DEF,
  parameter int NUMVBNK = NUMVBNK_DEF,
  parameter int BITVBNK = BITVBNK_DEF,
  parameter int BITREQ  = BITREQ_DEF
) (
  input  logic [NUMREQ-1:0]  pend,
  input  logic [BITVBNK-1:0] bank [NUMREQ],
  input  logic [BITREQ-1:0]  rr,
  input  logic               ready,
  output logic [NUMREQ-1:0]  gnt,
  output logic [BITREQ-1:0]  port_idx [NUMWRPT],
  output logic [NUMWRPT-1:0] port_vld,
  output logic [BITREQ:0]    conf_num
);

  localparam int PCW = $clog2(NUMWRPT + 1);
  localparam logic [PCW-1:0] PMAX = PCW'(NUMWRPT);

  always_comb begin
    logic [NUMVBNK-1:0] claimed;
    logic [PCW-1:0]     used;
    logic [BITREQ-1:0]  idx;
    logic [BITVBNK-1:0] b;
    gnt      = '0;
    port_vld = '0;
    conf_num = '0;
    claimed  = '0;
    used     = '0;
    idx      = '0;
    b        = '0;
    for (int k = 0; k < NUMWRPT; k++) begin
      port_idx[k] = '0;
    end
    if (ready) begin
      for (int j = 0; j < NUMREQ; j++) begin
        idx = BITREQ'((int'(rr) + j) % NUMREQ);
        if (pend[idx]) begin
          b = bank[idx];
          if (claimed[b]) begin
            // Once every port is taken a denial is port exhaustion, not a conflict.
            if (used != PMAX) begin
              conf_num = conf_num + 1'b1;
            end
          end else if (used != PMAX) begin
            gnt[idx]       = 1'b1;
            port_vld[used] = 1'b1;
            port_idx[used] = idx;
            claimed[b]     = 1'b1;
            used           = used + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/algo_4r6w1p_wr_sched.sv
// rtl/algo_4r6w1p_wr_sched.sv - write-port scheduler in front of the 4r6w banked core
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ready            core ready; low blocks all grants
//   req_vld/req_rdy  per-client request handshake
//   req_badr/radr/din  per-client bank, row and data (flattened)
//   write            registered core write enable per port
//   wr_badr/wr_radr/din  registered core bank, row and data per port
//   conf_cnt         saturating count of bank-conflict denials
module algo_4r6w1p_wr_sched
  import algo_4r6w1p_sched_pkg::*;
#(
  parameter int NUMREQ  = NUMREQ_DEF,
  parameter int NUMWRPT = NUMWRPT_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUMVBNK = NUMVBNK_DEF,
  parameter int BITVBNK = BITVBNK_DEF,
  parameter int BITVROW = BITVROW_DEF,
  parameter int BITREQ  = BITREQ_DEF,
  parameter int CNTW    = CNTW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMREQ-1:0]          req_vld,
  output logic [NUMREQ-1:0]          req_rdy,
  input  logic [NUMREQ*BITVBNK-1:0]  req_badr,
  input  logic [NUMREQ*BITVROW-1:0]  req_radr,
  input  logic [NUMREQ*WIDTH-1:0]    req_din,
  output logic [NUMWRPT-1:0]         write,
  output logic [NUMWRPT*BITVBNK-1:0] wr_badr,
  output logic [NUMWRPT*BITVROW-1:0] wr_radr,
  output logic [NUMWRPT*WIDTH-1:0]   din,
  output logic [CNTW-1:0]            conf_cnt
);

  localparam logic [BITREQ-1:0] RR_LAST = BITREQ'(NUMREQ - 1);

  logic [NUMREQ-1:0]  pend;
  logic [BITVBNK-1:0] hbadr [NUMREQ];
  logic [BITVROW-1:0] hradr [NUMREQ];
  logic [WIDTH-1:0]   hdin  [NUMREQ];
  logic [BITREQ-1:0]  rr;

  logic [NUMREQ-1:0]  gnt;
  logic [BITREQ-1:0]  port_idx [NUMWRPT];
  logic [NUMWRPT-1:0] port_vld;
  logic [BITREQ:0]    conf_num;
  logic [CNTW:0]      conf_sum;

  algo_4r6w1p_wr_grant #(
    .NUMREQ  (NUMREQ),
    .NUMWRPT (NUMWRPT),
    .NUMVBNK (NUMVBNK),
    .BITVBNK (BITVBNK),
    .BITREQ  (BITREQ)
  ) u_grant (
    .pend     (pend),
    .bank     (hbadr),
    .rr       (rr),
    .ready    (ready),
    .gnt      (gnt),
    .port_idx (port_idx),
    .port_vld (port_vld),
    .conf_num (conf_num)
  );

  // A holder being drained this cycle can take a new request at the same edge.
  assign req_rdy  = ~pend | gnt;
  assign conf_sum = {1'b0, conf_cnt} + (CNTW+1)'(conf_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      rr       <= '0;
      write    <= '0;
      wr_badr  <= '0;
      wr_radr  <= '0;
      din      <= '0;
      conf_cnt <= '0;
    end else begin
      for (int i = 0; i < NUMREQ; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          pend[i] <= 1'b1;
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (ready && |pend) begin
        rr <= (rr == RR_LAST) ? '0 : rr + 1'b1;
      end
      for (int k = 0; k < NUMWRPT; k++) begin
        write[k] <= port_vld[k];
        if (port_vld[k]) begin
          wr_badr[k*BITVBNK +: BITVBNK] <= hbadr[port_idx[k]];
          wr_radr[k*BITVROW +: BITVROW] <= hradr[port_idx[k]];
          din[k*WIDTH +: WIDTH]         <= hdin[port_idx[k]];
        end else begin
          wr_badr[k*BITVBNK +: BITVBNK] <= '0;
          wr_radr[k*BITVROW +: BITVROW] <= '0;
          din[k*WIDTH +: WIDTH]         <= '0;
        end
      end
      conf_cnt <= conf_sum[CNTW] ? '1 : conf_sum[CNTW-1:0];
    end
  end

  // Holder payload needs no reset; pend qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMREQ; i++) begin
      if (req_vld[i] && req_rdy[i]) begin
        hbadr[i] <= req_badr[i*BITVBNK +: BITVBNK];
        hradr[i] <= req_radr[i*BITVROW +: BITVROW];
        hdin[i]  <= req_din[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_algo_4r6w1p_wr_sched.sv
// tb/tb_algo_4r6w1p_wr_sched.sv - directed self-checking bench for the write scheduler
module tb_algo_4r6w1p_wr_sched;

  localparam int NUMREQ  = 8;
  localparam int NUMWRPT = 6;
  localparam int WIDTH   = 64;
  localparam int BITVBNK = 3;
  localparam int BITVROW = 13;
  localparam int CNTW    = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       ready;
  logic [NUMREQ-1:0]          req_vld;
  logic [NUMREQ-1:0]          req_rdy;
  logic [NUMREQ*BITVBNK-1:0]  req_badr;
  logic [NUMREQ*BITVROW-1:0]  req_radr;
  logic [NUMREQ*WIDTH-1:0]    req_din;
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITVBNK-1:0] wr_badr;
  logic [NUMWRPT*BITVROW-1:0] wr_radr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic [CNTW-1:0]            conf_cnt;

  int checks = 0;
  int errors = 0;

  algo_4r6w1p_wr_sched dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_badr (req_badr),
    .req_radr (req_radr),
    .req_din  (req_din),
    .write    (write),
    .wr_badr  (wr_badr),
    .wr_radr  (wr_radr),
    .din      (din),
    .conf_cnt (conf_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] b, input logic [12:0] r, input logic [63:0] d);
    req_vld[i] = 1'b1;
    req_badr[i*BITVBNK +: BITVBNK] = b;
    req_radr[i*BITVROW +: BITVROW] = r;
    req_din[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready = 1'b1;
    req_vld = '0;
    req_badr = '0;
    req_radr = '0;
    req_din = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready = 1'b1;
    req_vld = '1;
    req_badr = '1;
    req_radr = '1;
    req_din = '1;
    step();
    req_vld = '0;
    checks++; if (write !== 6'b0) begin errors++; $display("FAIL reset_write: got %b expected %b", write, 6'b0); end
    checks++; if (conf_cnt !== 16'd0) begin errors++; $display("FAIL reset_conf: got %0d expected 0", conf_cnt); end
    checks++; if (req_rdy !== 8'hFF) begin errors++; $display("FAIL reset_rdy: got %b expected 11111111", req_rdy); end
    checks++; if (wr_badr !== '0 || wr_radr !== '0 || din !== '0) begin errors++; $display("FAIL reset_outputs: badr %h radr %h expected 0", wr_badr, wr_radr); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(2, 3'd5, 13'h1A3, 64'hDEAD);
    step();
    req_vld = '0;
    checks++; if (write !== 6'b0) begin errors++; $display("FAIL single_latency: got %b expected %b", write, 6'b0); end
    step();
    checks++; if (write !== 6'b000001) begin errors++; $display("FAIL single_write: got %b expected 000001", write); end
    checks++; if (wr_badr[2:0] !== 3'd5) begin errors++; $display("FAIL single_badr: got %0d expected 5", wr_badr[2:0]); end
    checks++; if (wr_radr[12:0] !== 13'h1A3) begin errors++; $display("FAIL single_radr: got %h expected 1a3", wr_radr[12:0]); end
    checks++; if (din[63:0] !== 64'hDEAD) begin errors++; $display("FAIL single_din: got %h expected dead", din[63:0]); end
    checks++; if (conf_cnt !== 16'd0) begin errors++; $display("FAIL single_conf: got %0d expected 0", conf_cnt); end
    step();
    checks++; if (write !== 6'b0) begin errors++; $display("FAIL single_drain: got %b expected 000000", write); end
  endtask

  task automatic test_all_distinct();
    do_reset();
    for (int i = 0; i < NUMREQ; i++) set_req(i, 3'(i), 13'(16'h100 + i), 64'(64'hA0 + i));
    step();
    req_vld = '0;
    step();
    checks++; if (write !== 6'b111111) begin errors++; $display("FAIL distinct_c1_write: got %b expected 111111", write); end
    checks++; if (wr_badr !== {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL distinct_c1_badr: got %h expected %h", wr_badr, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}); end
    checks++; if (din[5*WIDTH +: WIDTH] !== 64'hA5) begin errors++; $display("FAIL distinct_c1_din5: got %h expected a5", din[5*WIDTH +: WIDTH]); end
    step();
    checks++; if (write !== 6'b000011) begin errors++; $display("FAIL distinct_c2_write: got %b expected 000011", write); end
    checks++; if (wr_badr[5:0] !== {3'd7, 3'd6}) begin errors++; $display("FAIL distinct_c2_badr: got %h expected %h", wr_badr[5:0], {3'd7, 3'd6}); end
    checks++; if (wr_radr[2*BITVROW-1:BITVROW] !== 13'h107) begin errors++; $display("FAIL distinct_c2_radr1: got %h expected 107", wr_radr[2*BITVROW-1:BITVROW]); end
    checks++; if (conf_cnt !== 16'd0) begin errors++; $display("FAIL distinct_conf: got %0d expected 0", conf_cnt); end
  endtask

  task automatic test_conflict();
    logic [12:0] exp_row [3];
    logic [15:0] exp_conf [3];
    logic        dup;
    exp_row[0] = 13'h010; exp_row[1] = 13'h030; exp_row[2] = 13'h050;
    exp_conf[0] = 16'd2; exp_conf[1] = 16'd3; exp_conf[2] = 16'd3;
    do_reset();
    set_req(0, 3'd4, 13'h010, 64'h1);
    set_req(3, 3'd4, 13'h030, 64'h3);
    set_req(5, 3'd4, 13'h050, 64'h5);
    step();
    req_vld = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (write !== 6'b000001) begin errors++; $display("FAIL conflict_write_c%0d: got %b expected 000001", c, write); end
      checks++; if (wr_radr[12:0] !== exp_row[c]) begin errors++; $display("FAIL conflict_row_c%0d: got %h expected %h", c, wr_radr[12:0], exp_row[c]); end
      checks++; if (conf_cnt !== exp_conf[c]) begin errors++; $display("FAIL conflict_conf_c%0d: got %0d expected %0d", c, conf_cnt, exp_conf[c]); end
      dup = 1'b0;
      for (int a = 0; a < NUMWRPT; a++)
        for (int b = a + 1; b < NUMWRPT; b++)
          if (write[a] && write[b] && wr_badr[a*3 +: 3] == wr_badr[b*3 +: 3]) dup = 1'b1;
      checks++; if (dup !== 1'b0) begin errors++; $display("FAIL conflict_unique_bank_c%0d: got dup=%b expected 0", c, dup); end
    end
  endtask

  task automatic test_starvation();
    int seen;
    do_reset();
    set_req(1, 3'd2, 13'h011, 64'h11);
    set_req(7, 3'd2, 13'h077, 64'h77);
    step();
    req_vld[7] = 1'b0;
    seen = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      step();
      if (write[0] && wr_radr[12:0] == 13'h077) seen = c;
    end
    checks++; if (seen !== 3) begin errors++; $display("FAIL starvation_grant_cycle: got %0d expected 3", seen); end
    checks++; if (conf_cnt !== 16'd3) begin errors++; $display("FAIL starvation_conf: got %0d expected 3", conf_cnt); end
    req_vld = '0;
  endtask

  task automatic test_ready_low();
    do_reset();
    ready = 1'b0;
    set_req(1, 3'd1, 13'h001, 64'h101);
    set_req(4, 3'd4, 13'h004, 64'h104);
    set_req(6, 3'd6, 13'h006, 64'h106);
    step();
    req_vld = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (write !== 6'b0) begin errors++; $display("FAIL ready_low_write_c%0d: got %b expected 000000", c, write); end
    end
    checks++; if (req_rdy !== 8'b10101101) begin errors++; $display("FAIL ready_low_rdy: got %b expected 10101101", req_rdy); end
    checks++; if (dut.rr !== 3'd0) begin errors++; $display("FAIL ready_low_rr: got %0d expected 0", dut.rr); end
    ready = 1'b1;
    step();
    checks++; if (write !== 6'b000111) begin errors++; $display("FAIL ready_rise_write: got %b expected 000111", write); end
    checks++; if (wr_badr[8:0] !== {3'd6, 3'd4, 3'd1}) begin errors++; $display("FAIL ready_rise_badr: got %h expected %h", wr_badr[8:0], {3'd6, 3'd4, 3'd1}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    set_req(0, 3'd3, 13'h0, 64'h0);
    set_req(1, 3'd3, 13'h1, 64'h1);
    set_req(2, 3'd5, 13'h2, 64'h2);
    set_req(3, 3'd5, 13'h3, 64'h3);
    step();
    req_vld = '0;
    ready = 1'b1;
    step();
    checks++; if (conf_cnt !== 16'd2) begin errors++; $display("FAIL mid_pre_conf: got %0d expected 2", conf_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (write !== 6'b0) begin errors++; $display("FAIL mid_rst_write: got %b expected 000000", write); end
    checks++; if (conf_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_conf: got %0d expected 0", conf_cnt); end
    checks++; if (req_rdy !== 8'hFF) begin errors++; $display("FAIL mid_rst_rdy: got %b expected 11111111", req_rdy); end
    step();
    checks++; if (write !== 6'b0) begin errors++; $display("FAIL mid_rst_discard: got %b expected 000000", write); end
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b0;
    req_vld = '0;
    req_badr = '0;
    req_radr = '0;
    req_din = '0;
    test_reset();
    test_single_write();
    test_all_distinct();
    test_conflict();
    test_starvation();
    test_ready_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/algo_4r6w1p_wr_sched.md
Name: algo_4r6w1p_wr_sched

Overview:
Write-port scheduler in front of the 4r6w banked core. It collects write requests from NUMREQ independent clients, each behind a one-entry holding register. Each cycle it packs up to NUMWRPT pending requests onto the core's write ports so that no two granted writes target the same bank, which is the write bank-conflict rule the core's assertions enforce. Round-robin rotation bounds starvation.

Parameters:
NUMREQ, 8, number of write clients
NUMWRPT, 6, core write ports per cycle
WIDTH, 64, data width
NUMVBNK, 8, number of banks
BITVBNK, 3, bank address width
BITVROW, 13, row address width
BITREQ, 3, clog2(NUMREQ)
CNTW, 16, conflict counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ready  in  1  core ready; low means no grants
req_vld  in  NUMREQ  client request valid
req_rdy  out  NUMREQ  client may present request
req_badr  in  NUMREQ*BITVBNK  client bank address
req_radr  in  NUMREQ*BITVROW  client row address
req_din  in  NUMREQ*WIDTH  client write data
write  out  NUMWRPT  core write enable per port
wr_badr  out  NUMWRPT*BITVBNK  core bank address per port
wr_radr  out  NUMWRPT*BITVROW  core row address per port
din  out  NUMWRPT*WIDTH  core write data per port
conf_cnt  out  CNTW  saturating bank-conflict denial count

Behaviour:
- Reset (rst=1 at posedge): pend[]=0, rr=0, write=0, wr_badr/wr_radr/din=0, conf_cnt=0. Reset asserted mid-operation discards all held requests. No write issues in the cycle after reset.
- Holding register per client: pend[i], hbadr[i], hradr[i], hdin[i].
- req_rdy[i] = !pend[i] | gnt[i]. This is combinational from registered state and the grant, with no path from req_vld.
- Accept: req_vld[i] & req_rdy[i] loads the holding register and sets pend[i] at the next edge.
- Grant without accept clears pend[i]. Grant with accept in the same cycle keeps pend[i]=1 and loads the new request, giving back-to-back throughput of 1 per client per cycle.
- Grant (combinational, only when ready=1):
  - Scan clients in order rr, rr+1, ..., rr+NUMREQ-1, taken mod NUMREQ.
  - Client i is granted iff pend[i], hbadr[i] is not already claimed this cycle, and fewer than NUMWRPT grants have been made so far.
  - The k-th granted client in scan order drives port k. Ports k >= grant count are idle.
- Output register:
  - write[k] <= port k used.
  - wr_badr/wr_radr/din[k] <= the granted client's held fields.
  - Idle ports drive write=0 and hold address/data at 0.
- Latency: request accepted at edge t → pend visible during cycle t → write asserted after edge t+1, assuming no conflict.
- Rotation: rr <= (rr+1) mod NUMREQ on every cycle where ready=1 and |pend. Otherwise rr holds. Any pending client reaches top priority within NUMREQ ready cycles, and top priority is always granted (bank free, port 0 free). The starvation bound is NUMREQ cycles.
- ready=0: gnt=0, write<=0, rr holds, and held requests persist. req_rdy=!pend still allows loading into empty holders.
- conf_cnt increments by the number of clients denied solely because their bank was already claimed. Denials due only to port exhaustion are not counted. The count saturates at 2^CNTW-1 and never wraps.
- Invariant: the registered write vector never contains two set ports with equal wr_badr.

Decomposition:
- Package algo_4r6w1p_sched_pkg holds:
  - typedefs bank_t [BITVBNK-1:0], row_t [BITVROW-1:0], reqidx_t [BITREQ-1:0];
  - struct wreq_t {bank_t badr; row_t radr; logic [WIDTH-1:0] din};
  - constant NUMWRPT_DEF=6.
- Sub-module algo_4r6w1p_wr_grant holds the purely combinational rotating scan. It takes pend, bank vector, rr and ready. It produces gnt[NUMREQ], the per-port client index plus valid, and the conflict denial count. The top level owns the holders, rr, output registers and counter.

Test Plan:
- Reset then a single write: client 2 sends bank 5, row 0x1A3, data 0xDEAD → write=6'b000001, wr_badr[0]=5, wr_radr[0]=0x1A3, din[0]=0xDEAD two edges after accept. conf_cnt=0.
- All 8 clients pend on distinct banks 0..7 with rr=0 → clients 0..5 granted on ports 0..5. Clients 6 and 7 are granted next cycle on ports 0..1 and conf_cnt stays 0.
- Clients 0, 3 and 5 all target bank 4 with rr=0 → cycle 1 grants only client 0 (conf_cnt+=2), cycle 2 grants client 3 (+1), cycle 3 grants client 5. No two set write ports ever share a bank.
- Starvation: client 1 continuously re-requests bank 2 and client 7 holds bank 2 → client 7 is granted within 8 cycles of pending.
- ready=0 for 5 cycles with 3 requests pending → write=0 throughout and rr is frozen. After ready rises, all 3 are issued in the first cycle.
- rst asserted while 4 requests are pending → next cycle pend=0, write=0, conf_cnt=0, and req_rdy is all ones.
